// File: rtl/floor_request_scheduler_if.sv
// Bundle between the floor-key/movement/door datapath and the LOOK scheduler.
// FIRE_RECALL_EN adds the level input `recall`.
interface floor_request_scheduler_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  // Signalling: tick, call_req and move_done are one-cycle pulses consumed on
  // the edge they are high; door_closed, overload, current_floor (and recall)
  // are levels; every scheduler output is a registered level.
  logic                  tick;
  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  move_done;
  logic                  door_closed;
  logic                  overload;
`ifdef FIRE_RECALL_EN
  logic                  recall;
`endif
  logic [NUM_FLOORS-1:0] pending;
  logic [1:0]            state;
  logic                  dir_up;
  logic                  move_up;
  logic                  move_down;
  logic                  door_open_cmd;

  modport master (
    output tick, call_req, current_floor, move_done, door_closed, overload,
`ifdef FIRE_RECALL_EN
    output recall,
`endif
    input  pending, state, dir_up, move_up, move_down, door_open_cmd
  );

  modport slave (
    input  tick, call_req, current_floor, move_done, door_closed, overload,
`ifdef FIRE_RECALL_EN
    input  recall,
`endif
    output pending, state, dir_up, move_up, move_down, door_open_cmd
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// LOOK-algorithm elevator scheduler: latches calls, picks sweep direction,
// commands floor steps and door dwell. Optional fire recall via FIRE_RECALL_EN.
module floor_request_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int DWELL_TICKS = 8
) (
  input logic                        clock,
  input logic                        reset,
  floor_request_scheduler_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_OPEN  = 2'b01,
    S_MOVE  = 2'b10,
    S_CLOSE = 2'b11
  } state_t;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] BOT_FLOOR = '0;
  localparam logic [7:0]         DWELL_LD  = 8'(DWELL_TICKS);

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  dir_up_q, dir_up_d;
  logic                  move_up_q, move_up_d;
  logic                  move_down_q, move_down_d;
  logic                  door_open_q, door_open_d;
  logic [7:0]            dwell_q, dwell_d;

  logic [NUM_FLOORS-1:0] req;
  logic                  above, below, here, choose_up;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      dir_up_q    <= 1'b1;
      move_up_q   <= 1'b0;
      move_down_q <= 1'b0;
      door_open_q <= 1'b0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      move_up_q   <= move_up_d;
      move_down_q <= move_down_d;
      door_open_q <= door_open_d;
      dwell_q     <= dwell_d;
    end
  end

  always_comb begin
    req = pending_q | bus.call_req;
`ifdef FIRE_RECALL_EN
    if (bus.recall) req = '0;
`endif
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > bus.current_floor) above = above | req[i];
      if (FLOOR_W'(i) < bus.current_floor) below = below | req[i];
    end
    here = req[bus.current_floor];

    // Keep sweeping while calls remain ahead, otherwise turn around.
    if (dir_up_q && above)       choose_up = 1'b1;
    else if (!dir_up_q && below) choose_up = 1'b0;
    else if (above)              choose_up = 1'b1;
    else if (below)              choose_up = 1'b0;
    else                         choose_up = dir_up_q;

    state_d   = state_q;
    dir_up_d  = dir_up_q;
    pending_d = req;
    dwell_d   = dwell_q;

    case (state_q)
      S_IDLE: begin
        if (here) state_d = S_OPEN;
        else if (above || below) begin
          state_d  = S_MOVE;
          dir_up_d = choose_up;
        end
      end
      S_OPEN: begin
        if (bus.tick && dwell_q != 8'd0) dwell_d = dwell_q - 8'd1;
        if (here) dwell_d = DWELL_LD;
        else if (dwell_q == 8'd0 && !bus.overload) state_d = S_CLOSE;
      end
      S_CLOSE: begin
        if (here || bus.overload) state_d = S_OPEN;
        else if (bus.door_closed) begin
          if (above || below) begin
            state_d  = S_MOVE;
            dir_up_d = choose_up;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_MOVE: begin
        if (bus.move_done) begin
          if (here) state_d = S_OPEN;
          else if (above || below) dir_up_d = choose_up;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef FIRE_RECALL_EN
    // Recall: head for floor 0 and park there with the door open.
    if (bus.recall) begin
      case (state_q)
        S_IDLE: begin
          state_d  = (bus.current_floor == BOT_FLOOR) ? S_OPEN : S_MOVE;
          dir_up_d = 1'b0;
        end
        S_OPEN: begin
          if (bus.current_floor != BOT_FLOOR) state_d = S_CLOSE;
          else begin
            state_d = S_OPEN;
            dwell_d = dwell_q;
          end
        end
        S_CLOSE: begin
          if (bus.current_floor == BOT_FLOOR) state_d = S_OPEN;
          else if (bus.door_closed) begin
            state_d  = S_MOVE;
            dir_up_d = 1'b0;
          end else state_d = S_CLOSE;
        end
        default: begin
          dir_up_d = 1'b0;
          state_d  = (bus.move_done && bus.current_floor == BOT_FLOOR) ? S_OPEN : S_MOVE;
        end
      endcase
    end
`endif

    if (state_d == S_MOVE &&
        ((dir_up_d && bus.current_floor == TOP_FLOOR) ||
         (!dir_up_d && bus.current_floor == BOT_FLOOR)))
      state_d = S_IDLE;

    if (state_d == S_OPEN && state_q != S_OPEN) dwell_d = DWELL_LD;
    // The floor being served never latches while the door cycle is active.
    if (state_d == S_OPEN || state_q == S_OPEN || state_q == S_CLOSE)
      pending_d[bus.current_floor] = 1'b0;
  end

  always_comb begin
    move_up_d   = (state_d == S_MOVE) && dir_up_d;
    move_down_d = (state_d == S_MOVE) && !dir_up_d;
    door_open_d = (state_d == S_OPEN);
  end

  assign bus.pending       = pending_q;
  assign bus.state         = state_q;
  assign bus.dir_up        = dir_up_q;
  assign bus.move_up       = move_up_q;
  assign bus.move_down     = move_down_q;
  assign bus.door_open_cmd = door_open_q;
endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: reset, LOOK sweeps, door dwell,
// reopen, overload hold, simultaneous arrival call, mid-move reset, recall.
module tb_floor_request_scheduler;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_OPEN  = 2'b01;
  localparam logic [1:0] ST_MOVE  = 2'b10;
  localparam logic [1:0] ST_CLOSE = 2'b11;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  floor_request_scheduler_if #(.NUM_FLOORS(4), .FLOOR_W(2)) bus ();

  floor_request_scheduler #(.NUM_FLOORS(4), .FLOOR_W(2), .DWELL_TICKS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_call(input logic [3:0] c);
    bus.call_req = c;
    cyc();
    bus.call_req = 4'b0000;
  endtask

  task automatic do_move(input logic [1:0] nf);
    bus.current_floor = nf;
    bus.move_done = 1'b1;
    cyc();
    bus.move_done = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.tick = 1'b0;
    bus.call_req = 4'b0000;
    bus.current_floor = 2'd0;
    bus.move_done = 1'b0;
    bus.door_closed = 1'b0;
    bus.overload = 1'b0;
`ifdef FIRE_RECALL_EN
    bus.recall = 1'b0;
`endif
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_dir_up", 32'(bus.dir_up), 32'h1);
    chk("rst_move", 32'({bus.move_up, bus.move_down}), 32'h0);
    chk("rst_door", 32'(bus.door_open_cmd), 32'h0);

    // Call at idle: floor 0 -> 3
    pulse_call(4'b1000);
    chk("idle_pending", 32'(bus.pending), 32'h8);
    chk("idle_state", 32'(bus.state), 32'(ST_MOVE));
    chk("idle_move", 32'({bus.move_up, bus.move_down}), 32'h2);
    do_move(2'd1);
    do_move(2'd2);
    chk("pass_state", 32'(bus.state), 32'(ST_MOVE));
    do_move(2'd3);
    chk("arrive_state", 32'(bus.state), 32'(ST_OPEN));
    chk("arrive_pending", 32'(bus.pending), 32'h0);
    chk("arrive_move", 32'({bus.move_up, bus.move_down}), 32'h0);
    chk("arrive_door", 32'(bus.door_open_cmd), 32'h1);
    ticks(7);
    chk("dwell7_state", 32'(bus.state), 32'(ST_OPEN));
    ticks(1);
    chk("dwell8_state", 32'(bus.state), 32'(ST_CLOSE));
    chk("close_door", 32'(bus.door_open_cmd), 32'h0);

    // Reopen from CLOSE on a call at the current floor
    pulse_call(4'b1000);
    chk("reopen_state", 32'(bus.state), 32'(ST_OPEN));
    chk("reopen_pending", 32'(bus.pending), 32'h0);
    ticks(7);
    chk("reopen_dwell7", 32'(bus.state), 32'(ST_OPEN));
    ticks(1);
    chk("reopen_dwell8", 32'(bus.state), 32'(ST_CLOSE));
    bus.door_closed = 1'b1;
    cyc();
    chk("to_idle", 32'(bus.state), 32'(ST_IDLE));
    bus.door_closed = 1'b0;

    // Overload hold in OPEN, then overload reopen from CLOSE
    pulse_call(4'b1000);
    chk("ovl_open", 32'(bus.state), 32'(ST_OPEN));
    bus.overload = 1'b1;
    ticks(20);
    chk("ovl_hold", 32'(bus.state), 32'(ST_OPEN));
    bus.overload = 1'b0;
    cyc();
    chk("ovl_release", 32'(bus.state), 32'(ST_CLOSE));
    bus.overload = 1'b1;
    cyc();
    chk("ovl_reopen", 32'(bus.state), 32'(ST_OPEN));
    bus.overload = 1'b0;
    cyc();
    chk("ovl_reload", 32'(bus.state), 32'(ST_OPEN));
    ticks(8);
    bus.door_closed = 1'b1;
    cyc();
    chk("ovl_idle", 32'(bus.state), 32'(ST_IDLE));
    bus.door_closed = 1'b0;

    // Down to floor 1, then up with a later call below: LOOK order
    pulse_call(4'b0010);
    chk("down_move", 32'({bus.move_up, bus.move_down}), 32'h1);
    chk("down_dir", 32'(bus.dir_up), 32'h0);
    do_move(2'd2);
    do_move(2'd1);
    chk("f1_open", 32'(bus.state), 32'(ST_OPEN));
    ticks(8);
    pulse_call(4'b1000);
    chk("f1_close_pend", 32'(bus.pending), 32'h8);
    bus.door_closed = 1'b1;
    cyc();
    bus.door_closed = 1'b0;
    chk("up_state", 32'(bus.state), 32'(ST_MOVE));
    chk("up_dir", 32'(bus.dir_up), 32'h1);
    chk("up_move", 32'({bus.move_up, bus.move_down}), 32'h2);
    pulse_call(4'b0001);
    chk("both_pend", 32'(bus.pending), 32'h9);
    do_move(2'd2);
    chk("keep_up", 32'({bus.move_up, bus.move_down}), 32'h2);
    do_move(2'd3);
    chk("f3_first", 32'(bus.state), 32'(ST_OPEN));
    chk("f3_pend", 32'(bus.pending), 32'h1);
    ticks(8);
    bus.door_closed = 1'b1;
    cyc();
    bus.door_closed = 1'b0;
    chk("rev_dir", 32'(bus.dir_up), 32'h0);
    chk("rev_move", 32'({bus.move_up, bus.move_down}), 32'h1);
    do_move(2'd2);
    do_move(2'd1);
    do_move(2'd0);
    chk("f0_open", 32'(bus.state), 32'(ST_OPEN));
    chk("f0_pend", 32'(bus.pending), 32'h0);
    chk("f0_no_down", 32'(bus.move_down), 32'h0);

    // Call arriving together with move_done stops the car there
    ticks(8);
    bus.door_closed = 1'b1;
    cyc();
    pulse_call(4'b1000);
    bus.door_closed = 1'b0;
    do_move(2'd1);
    bus.call_req = 4'b0100;
    do_move(2'd2);
    bus.call_req = 4'b0000;
    chk("sim_state", 32'(bus.state), 32'(ST_OPEN));
    chk("sim_pend", 32'(bus.pending), 32'h8);

    // Reset mid-MOVE with two calls outstanding
    pulse_call(4'b0010);
    ticks(8);
    bus.door_closed = 1'b1;
    cyc();
    bus.door_closed = 1'b0;
    chk("pre_rst_state", 32'(bus.state), 32'(ST_MOVE));
    chk("pre_rst_pend", 32'(bus.pending), 32'ha);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.current_floor = 2'd0;
    chk("mid_rst_state", 32'(bus.state), 32'(ST_IDLE));
    chk("mid_rst_pend", 32'(bus.pending), 32'h0);
    chk("mid_rst_move", 32'({bus.move_up, bus.move_down}), 32'h0);
    chk("mid_rst_dir", 32'(bus.dir_up), 32'h1);

`ifdef FIRE_RECALL_EN
    // Fire recall from floor 2 while heading up to 3
    pulse_call(4'b1000);
    do_move(2'd1);
    do_move(2'd2);
    bus.recall = 1'b1;
    cyc();
    chk("rc_pend", 32'(bus.pending), 32'h0);
    chk("rc_dir", 32'(bus.dir_up), 32'h0);
    chk("rc_move", 32'({bus.move_up, bus.move_down}), 32'h1);
    pulse_call(4'b0100);
    chk("rc_ignore", 32'(bus.pending), 32'h0);
    do_move(2'd1);
    do_move(2'd0);
    chk("rc_open", 32'(bus.state), 32'(ST_OPEN));
    ticks(20);
    chk("rc_hold", 32'(bus.state), 32'(ST_OPEN));
    bus.recall = 1'b0;
    ticks(7);
    chk("rc_dwell7", 32'(bus.state), 32'(ST_OPEN));
    ticks(1);
    chk("rc_close", 32'(bus.state), 32'(ST_CLOSE));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
